// File: rtl/vc_plane_link_scheduler_pkg.sv
// ============================================================================
// Module      : noc_pkg
// Description : Shared NoC constants, flit type and parameter helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_pkg;

  localparam int NOC_VC         = 4;
  localparam int NOC_DATA_WIDTH = 32;
  localparam int VC_IDX_W       = $clog2(NOC_VC);

  typedef logic [NOC_DATA_WIDTH-1:0] flit_t;

  function automatic bit isPow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vc_plane_link_scheduler_fifo.sv
// ============================================================================
// Module      : vc_flit_fifo
// Description : Per-VC synchronous flit FIFO with push/pop/full/empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_flit_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] pushData,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] headData,
  output logic                  full,
  output logic                  empty
);

  localparam int c_ADDR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0]   r_wrPtr;
  logic [c_ADDR_W-1:0]   r_rdPtr;
  logic [c_ADDR_W:0]     r_count;
  logic                  w_doPush;
  logic                  w_doPop;

  assign full     = (r_count == (c_ADDR_W+1)'(FIFO_DEPTH));
  assign empty    = (r_count == '0);
  assign w_doPush = push && !full;
  assign w_doPop  = pop && !empty;
  assign headData = r_mem[r_rdPtr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= pushData;
  end

endmodule

`default_nettype wire

// File: rtl/vc_plane_link_scheduler.sv
// ============================================================================
// Module      : vc_plane_link_scheduler
// Description : Buffers flits per VC and drains the selected VC plane onto a
//               single registered valid/ready link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_plane_link_scheduler
  import noc_pkg::*;
#(
  parameter int VC         = NOC_VC,
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [VC:0]              VCPlaneSelector,
  input  logic [VC-1:0]            in_valid,
  input  logic [VC*DATA_WIDTH-1:0] in_data,
  output logic [VC-1:0]            in_ready,
  output logic                     link_valid,
  output logic [DATA_WIDTH-1:0]    link_data,
  output logic [$clog2(VC)-1:0]    link_vc,
  input  logic                     link_ready,
  output logic                     sel_err
);

  localparam int c_VC_W = $clog2(VC);

  if (!isPow2(FIFO_DEPTH) || (FIFO_DEPTH < 2) || (VC < 2)) begin : g_badParams
    $error("vc_plane_link_scheduler: FIFO_DEPTH must be a power of two >= 2 and VC >= 2");
  end

  logic [DATA_WIDTH-1:0] w_head [VC];
  logic [VC-1:0]         w_full;
  logic [VC-1:0]         w_empty;
  logic [VC-1:0]         w_pop;
  logic [c_VC_W-1:0]     w_selIdx;
  logic                  w_selInRange;
  logic                  w_free;
  logic                  w_doPop;

  logic                  r_linkValid;
  logic [DATA_WIDTH-1:0] r_linkData;
  logic [c_VC_W-1:0]     r_linkVc;
  logic                  r_selErr;

  assign w_selInRange = (VCPlaneSelector < (VC+1)'(VC));
  assign w_selIdx     = VCPlaneSelector[c_VC_W-1:0];
  assign w_free       = !r_linkValid || link_ready;
  assign w_doPop      = w_selInRange && !w_empty[w_selIdx] && w_free;

  for (genvar i = 0; i < VC; i++) begin : g_vcFifo
    assign w_pop[i] = w_doPop && (w_selIdx == c_VC_W'(i));

    vc_flit_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (in_valid[i]),
      .pushData (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .pop      (w_pop[i]),
      .headData (w_head[i]),
      .full     (w_full[i]),
      .empty    (w_empty[i])
    );
  end

  assign in_ready = ~w_full;

  // Data/tag only move on a pop, which keeps them stable across a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_linkValid <= 1'b0;
      r_linkData  <= '0;
      r_linkVc    <= '0;
      r_selErr    <= 1'b0;
    end else begin
      if (w_doPop) begin
        r_linkValid <= 1'b1;
        r_linkData  <= w_head[w_selIdx];
        r_linkVc    <= w_selIdx;
      end else if (link_ready) begin
        r_linkValid <= 1'b0;
      end
      if (!w_selInRange) r_selErr <= 1'b1;
    end
  end

  assign link_valid = r_linkValid;
  assign link_data  = r_linkData;
  assign link_vc    = r_linkVc;
  assign sel_err    = r_selErr;

endmodule

`default_nettype wire

// File: tb/tb_vc_plane_link_scheduler.sv
// ============================================================================
// Module      : tb_vc_plane_link_scheduler
// Description : Directed scoreboard bench for vc_plane_link_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vc_plane_link_scheduler;
  import noc_pkg::*;

  localparam int c_VC = 4;
  localparam int c_DW = 32;

  typedef struct packed {
    logic [c_DW-1:0] data;
    logic [1:0]      vc;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic [c_VC:0]        VCPlaneSelector;
  logic [c_VC-1:0]      in_valid;
  logic [c_VC*c_DW-1:0] in_data;
  logic [c_VC-1:0]      in_ready;
  logic                 link_valid;
  logic [c_DW-1:0]      link_data;
  logic [1:0]           link_vc;
  logic                 link_ready;
  logic                 sel_err;

  int   checks = 0;
  int   errors = 0;
  exp_t sbQueue[$];

  vc_plane_link_scheduler #(
    .VC         (c_VC),
    .DATA_WIDTH (c_DW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .VCPlaneSelector (VCPlaneSelector),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .link_valid      (link_valid),
    .link_data       (link_data),
    .link_vc         (link_vc),
    .link_ready      (link_ready),
    .sel_err         (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setFlit(input int vc, input flit_t f);
    in_valid[vc]               = 1'b1;
    in_data[vc*c_DW +: c_DW]   = f;
  endtask

  task automatic expectFlit(input logic [c_DW-1:0] d, input logic [1:0] v);
    exp_t e;
    e.data = d;
    e.vc   = v;
    sbQueue.push_back(e);
  endtask

  // Monitor: every completed handshake must match the scoreboard head, and
  // a stalled flit must not change before it is accepted.
  logic            stallPrev = 1'b0;
  logic [c_DW-1:0] stallData;
  logic [1:0]      stallVc;

  always @(negedge clk) begin
    if (!rst) begin
      stallPrev = 1'b0;
    end else begin
      if (stallPrev && link_valid) begin
        check("stall_data_stable", 64'(link_data), 64'(stallData));
        check("stall_vc_stable", 64'(link_vc), 64'(stallVc));
      end
      if (link_valid && link_ready) begin
        if (sbQueue.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_flit: got data 0x%0h vc %0d, expected no flit", link_data, link_vc);
        end else begin
          exp_t e;
          e = sbQueue.pop_front();
          check("sb_data", 64'(link_data), 64'(e.data));
          check("sb_vc", 64'(link_vc), 64'(e.vc));
        end
      end
      stallPrev = link_valid && !link_ready;
      stallData = link_data;
      stallVc   = link_vc;
    end
  end

  initial begin
    rst             = 1'b0;
    VCPlaneSelector = '0;
    in_valid        = '0;
    in_data         = '0;
    link_ready      = 1'b1;
    #1;
    check("rst_link_valid", 64'(link_valid), 64'd0);
    check("rst_link_data", 64'(link_data), 64'd0);
    check("rst_link_vc", 64'(link_vc), 64'd0);
    check("rst_sel_err", 64'(sel_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'hF);
    step();
    step();
    rst = 1'b1;

    // Idle selector sweep: nothing to drain.
    for (int s = 0; s < 4; s++) begin
      VCPlaneSelector = 5'(s);
      step();
      check("idle_link_valid", 64'(link_valid), 64'd0);
      check("idle_in_ready", 64'(in_ready), 64'hF);
      check("idle_sel_err", 64'(sel_err), 64'd0);
    end

    // Single flit on VC2, two-cycle latency.
    VCPlaneSelector = 5'd0;
    setFlit(2, 32'hA0);
    step();
    in_valid        = '0;
    VCPlaneSelector = 5'd2;
    expectFlit(32'hA0, 2'd2);
    step();
    check("lat_link_valid", 64'(link_valid), 64'd1);
    check("lat_link_data", 64'(link_data), 64'hA0);
    check("lat_link_vc", 64'(link_vc), 64'd2);
    VCPlaneSelector = 5'd0;
    step();
    check("lat_valid_drop", 64'(link_valid), 64'd0);

    // Fill VC1 while unselected, then drain back to back.
    for (int i = 0; i < 4; i++) begin
      setFlit(1, flit_t'(32'h10 + i));
      step();
    end
    in_valid = '0;
    check("full_in_ready1", 64'(in_ready[1]), 64'd0);
    check("full_no_pop", 64'(link_valid), 64'd0);
    VCPlaneSelector = 5'd1;
    for (int i = 0; i < 4; i++) expectFlit(32'h10 + i, 2'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("burst_valid", 64'(link_valid), 64'd1);
      check("burst_data", 64'(link_data), 64'(32'h10 + i));
    end
    check("drained_in_ready", 64'(in_ready), 64'hF);
    VCPlaneSelector = 5'd0;
    step();

    // Backpressure: 0x55 held on the link while VC0 still has 0x66.
    VCPlaneSelector = 5'd2;
    setFlit(0, 32'h55);
    step();
    setFlit(0, 32'h66);
    step();
    in_valid        = '0;
    link_ready      = 1'b0;
    VCPlaneSelector = 5'd0;
    expectFlit(32'h55, 2'd0);
    expectFlit(32'h66, 2'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_valid", 64'(link_valid), 64'd1);
      check("bp_hold_data", 64'(link_data), 64'h55);
    end
    link_ready = 1'b1;
    step();
    check("bp_next_data", 64'(link_data), 64'h66);
    VCPlaneSelector = 5'd2;
    step();
    check("bp_drained", 64'(link_valid), 64'd0);

    // Out-of-range selector: no pop, sticky error.
    VCPlaneSelector = 5'd5;
    for (int v = 0; v < 4; v++) setFlit(v, flit_t'(32'hB0 + v));
    step();
    in_valid = '0;
    step();
    check("selerr_set", 64'(sel_err), 64'd1);
    check("selerr_no_pop", 64'(link_valid), 64'd0);
    for (int v = 0; v < 4; v++) expectFlit(32'hB0 + v, 2'(v));
    for (int v = 0; v < 4; v++) begin
      VCPlaneSelector = 5'(v);
      step();
      check("selerr_drain_data", 64'(link_data), 64'(32'hB0 + v));
    end
    VCPlaneSelector = 5'd0;
    step();
    check("selerr_sticky", 64'(sel_err), 64'd1);

    // Async reset with buffered flits and a stalled link flit.
    link_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setFlit(3, flit_t'(32'hC0 + i));
      step();
    end
    in_valid        = '0;
    VCPlaneSelector = 5'd3;
    step();
    VCPlaneSelector = 5'd0;
    check("pre_rst_valid", 64'(link_valid), 64'd1);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_valid", 64'(link_valid), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'hF);
    check("async_rst_sel_err", 64'(sel_err), 64'd0);
    step();
    rst             = 1'b1;
    link_ready      = 1'b1;
    VCPlaneSelector = 5'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_no_stale", 64'(link_valid), 64'd0);
    end
    check("post_rst_in_ready", 64'(in_ready), 64'hF);

    step();
    check("sb_empty", 64'(sbQueue.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vc_plane_link_scheduler.md
Name: vc_plane_link_scheduler

Overview:
- Output-side stage that consumes the VC plane selector produced by the VC plane controller.
- Buffers flits per virtual channel.
- In each cycle, drains only the VC plane currently selected onto the single shared physical link, through a registered valid/ready output stage.
- Sits between the router's per-VC switch outputs and the inter-router link.

Parameters:
- VC, 4, number of virtual channels; selector width is VC+1 bits.
- DATA_WIDTH, 32, flit width in bits.
- FIFO_DEPTH, 4, entries per VC FIFO; power of two, minimum 2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: one clock, asynchronous, active-low (rst=0 resets).
- VCPlaneSelector  input  VC+1  binary index of the active VC plane.
- in_valid  input  VC  per-VC flit valid.
- in_data  input  VC*DATA_WIDTH  per-VC flit; VC i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  output  VC  per-VC ready; equals that FIFO not full.
- link_valid  output  1  output flit valid.
- link_data  output  DATA_WIDTH  output flit.
- link_vc  output  $clog2(VC)  VC tag of the output flit.
- link_ready  input  1  downstream accepts the flit.
- sel_err  output  1  sticky flag: selector seen at a value >= VC.

Behaviour:
- Reset (rst low, asynchronous):
  - all FIFOs empty; in_ready all 1;
  - link_valid=0, link_data=0, link_vc=0, sel_err=0.
  - Reset asserted mid-operation discards all buffered and in-flight flits immediately.
- Push:
  - VC i accepts a flit when in_valid[i] && in_ready[i].
  - The flit is visible in FIFO i at the next edge.
  - All VCs may push in the same cycle.
- Output register:
  - "free" = !link_valid || link_ready.
- Pop (per cycle):
  - s = VCPlaneSelector.
  - Pop when s < VC, FIFO[s] is non-empty, and the output register is free.
  - On pop, at the next edge: link_data = head of FIFO[s], link_vc = s, link_valid = 1.
  - Otherwise, if link_ready, link_valid goes to 0.
  - Otherwise, hold.
- Latency: flit pushed at edge N, and selector==i during cycle N+1 with the register free, gives link_valid at edge N+2 (2 cycles).
- Throughput: one flit per cycle whenever the selector plane has data and link_ready=1.
- Link stability: while link_valid && !link_ready, link_data and link_vc stay stable (standard valid/ready).
- Boundary conditions:
  - Simultaneous push and pop on the same FIFO is legal at any occupancy.
    - Full FIFO: in_ready=0 that cycle, so no push; the pop frees a slot next cycle.
    - Empty FIFO: push only; a flit is never bypassed straight to the link in the same cycle.
  - Selector >= VC: no pop, and sel_err is set to 1 until reset.
  - Non-selected VCs never pop, even if the link is idle.
  - FIFO pointers wrap modulo FIFO_DEPTH; the count is $clog2(FIFO_DEPTH)+1 bits.
  - Non-power-of-two FIFO_DEPTH or VC < 2 is rejected by an elaboration assertion.
- Ordering: flits within one VC leave in FIFO order. Between VCs, order is set purely by the selector sequence.

Decomposition:
- Shared package noc_pkg:
  - VC_IDX_W = $clog2(VC);
  - flit_t typedef (logic [DATA_WIDTH-1:0]).
- Sub-module vc_flit_fifo, instantiated VC times:
  - synchronous FIFO with push/pop/full/empty;
  - same clk and active-low async rst;
  - registered storage.
- The top level holds the selector decode, the pop mux, the output register and sel_err.

Test Plan:
- Reset release, selector cycling 0,1,2,3, no inputs -> link_valid stays 0, in_ready=4'b1111, sel_err=0.
- Push 0xA0 into VC2 at edge 1, selector 2 in cycle 2, link_ready=1 -> link_valid=1, link_data=0xA0, link_vc=2 at edge 3; link_valid=0 at edge 4.
- Fill VC1 with 4 flits (0x10..0x13) while the selector never equals 1 -> in_ready[1]=0 after the 4th push. Selector then held at 1 with link_ready=1 -> 0x10,0x11,0x12,0x13 on consecutive cycles, then in_ready[1]=1.
- link_ready=0 with 0x55 on the link, VC0 non-empty, selector=0 -> link_data held at 0x55, no pop. Raising link_ready -> VC0 head appears the next cycle, with no loss or duplication.
- Drive selector=5 (VC=4) for one cycle with all FIFOs non-empty -> no pop that cycle, sel_err=1 and sticky until rst goes low.
- Assert rst asynchronously mid-cycle with 3 flits buffered and link_valid=1 -> link_valid=0 immediately; after release, in_ready=4'b1111 and no stale flit ever emitted.
